// File: rtl/shift_rows_stream.sv
// rtl/shift_rows_stream.sv - handshaked ShiftRows/InvShiftRows stage with registered ready (skid buffer)
// Inverse mode and the tag path exist only when SHIFT_ROWS_STREAM_INV_EN is defined.
module shift_rows_stream #(
    parameter int NB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:32*NB-1] in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:32*NB-1] out_data,
    output logic             out_inv
);
    localparam int W = 32 * NB;

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;

    // Rijndael row offsets; the wide block skips offset 2 on rows 2 and 3.
    function automatic int row_shift(input int r);
        return (NB == 8 && r >= 2) ? r + 1 : r;
    endfunction

    logic [0:W-1] fwd_data;
    logic [0:W-1] perm_data;

    always_comb begin
        fwd_data = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                fwd_data[8*(4*c+r) +: 8] = in_data[8*(4*((c + row_shift(r)) % NB) + r) +: 8];
            end
        end
    end

`ifdef SHIFT_ROWS_STREAM_INV_EN
    logic [0:W-1] inv_data;
    logic         main_inv_q;
    logic         skid_inv_q;

    always_comb begin
        inv_data = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                inv_data[8*(4*c+r) +: 8] = in_data[8*(4*((c - row_shift(r) + NB) % NB) + r) +: 8];
            end
        end
    end

    assign perm_data = in_inv ? inv_data : fwd_data;
    assign out_inv   = main_inv_q;
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign perm_data     = fwd_data;
    assign out_inv       = 1'b0;
`endif

    buf_state_t   state_q;
    logic [0:W-1] main_q;
    logic [0:W-1] skid_q;
    logic         out_valid_q;
    logic         ready_q;
    logic         accept;
    logic         emit;

    assign accept    = in_valid && ready_q;
    assign emit      = out_valid_q && out_ready;
    assign in_ready  = ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    // Words are permuted on the way in, so main/skid always hold finished results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b0;
`ifdef SHIFT_ROWS_STREAM_INV_EN
            main_inv_q  <= 1'b0;
            skid_inv_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        main_q      <= perm_data;
`ifdef SHIFT_ROWS_STREAM_INV_EN
                        main_inv_q  <= in_inv;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !emit) begin
                        skid_q     <= perm_data;
`ifdef SHIFT_ROWS_STREAM_INV_EN
                        skid_inv_q <= in_inv;
`endif
                        ready_q    <= 1'b0;
                        state_q    <= FULL;
                    end else if (accept) begin
                        main_q     <= perm_data;
`ifdef SHIFT_ROWS_STREAM_INV_EN
                        main_inv_q <= in_inv;
`endif
                    end else if (emit) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        main_q     <= skid_q;
                        skid_q     <= '0;
`ifdef SHIFT_ROWS_STREAM_INV_EN
                        main_inv_q <= skid_inv_q;
                        skid_inv_q <= 1'b0;
`endif
                        ready_q    <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
endmodule
